// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, divider FSM state
// encoding and the registered result-flag bundle.
package alu_pkg;

  // Opcode map (ALU_FUN)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_GT   = 4'd11;
  localparam logic [3:0] OP_LT   = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;
  localparam logic [3:0] OP_ZERO = 4'd15;

  // Iterative divider FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } div_state_e;

  // Result flags presented alongside ALU_OUT
  typedef struct packed {
    logic carry;
    logic arith;
    logic logic_op;
    logic cmp;
    logic shift;
    logic zero;
    logic div0;
  } alu_flags_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports: CLK/RST (sync, active-low); start loads dividend/divisor;
// busy (registered) is high while in DIV; done_c/quot_c/rem_c are
// combinational and valid in the last DIV cycle so the caller can
// register the result on the same edge that leaves DIV.
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] quot_c,
  output logic [WIDTH-1:0] rem_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned SW = WIDTH + 1;

  div_state_e       state_q, state_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic [WIDTH-1:0] rem_q, rem_nxt;
  logic [WIDTH-1:0] quo_q, quo_nxt;
  logic [WIDTH-1:0] dvs_q, dvs_nxt;

  logic [SW-1:0]    shifted;
  logic [SW-1:0]    diff;
  logic             borrow;

  // One restoring step: shift in next dividend bit, trial-subtract divisor
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign borrow  = diff[WIDTH];
  assign rem_c   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_c  = {quo_q[WIDTH-2:0], ~borrow};

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      busy    <= (state_nxt == ST_DIV);
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
      dvs_q   <= dvs_nxt;
    end
  end

  // Next-state and step control
  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    rem_nxt   = rem_q;
    quo_nxt   = quo_q;
    dvs_nxt   = dvs_q;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_DIV;
          count_nxt = CW'(WIDTH - 1);
          rem_nxt   = '0;
          quo_nxt   = dividend;
          dvs_nxt   = divisor;
        end
      end
      ST_DIV: begin
        rem_nxt = rem_c;
        quo_nxt = quot_c;
        if (count_q == '0) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          count_nxt = count_q - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential parametrised ALU: single-cycle arithmetic/logic/compare/shift
// plus an iterative divider. Results and flags are registered and held
// until the next OUT_VALID pulse.
// Ports: CLK, RST (sync, active-low); IN_VALID/A/B/ALU_FUN request;
// BUSY while dividing; OUT_VALID pulse with ALU_OUT, REM_OUT and flags.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             BUSY,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] REM_OUT,
  output logic             Carry_Flag,
  output logic             Arith_flag,
  output logic             Logic_flag,
  output logic             CMP_flag,
  output logic             Shift_flag,
  output logic             Zero_flag,
  output logic             DIV0_flag
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;

  logic             div_busy, div_done_c;
  logic [WIDTH-1:0] div_quot_c, div_rem_c;
  logic             accept, div_start;

  logic [SW-1:0]    add_w, sub_w;
  logic [PW-1:0]    prod;

  logic             res_valid;
  logic [WIDTH-1:0] res_alu, res_rem;
  alu_flags_t       res_flags;

  logic             valid_q;
  logic [WIDTH-1:0] alu_q, rem_q;
  alu_flags_t       flags_q;

  assign accept    = IN_VALID && !div_busy;
  assign div_start = accept && (ALU_FUN == OP_DIV) && (B != '0);

  assign add_w = SW'(A) + SW'(B);
  assign sub_w = SW'(A) - SW'(B);
  assign prod  = PW'(A) * PW'(B);

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .busy     (div_busy),
    .done_c   (div_done_c),
    .quot_c   (div_quot_c),
    .rem_c    (div_rem_c)
  );

  // Result selection; held values recirculate when nothing new completes
  always_comb begin
    res_valid = 1'b0;
    res_alu   = alu_q;
    res_rem   = rem_q;
    res_flags = flags_q;
    if (div_done_c) begin
      res_valid       = 1'b1;
      res_alu         = div_quot_c;
      res_rem         = div_rem_c;
      res_flags       = '0;
      res_flags.arith = 1'b1;
    end else if (accept && !div_start) begin
      res_valid = 1'b1;
      res_alu   = '0;
      res_rem   = '0;
      res_flags = '0;
      case (ALU_FUN)
        OP_ADD:  begin res_alu = add_w[WIDTH-1:0]; res_flags.carry = add_w[WIDTH]; res_flags.arith = 1'b1; end
        OP_SUB:  begin res_alu = sub_w[WIDTH-1:0]; res_flags.carry = sub_w[WIDTH]; res_flags.arith = 1'b1; end
        OP_MUL:  begin res_alu = prod[WIDTH-1:0]; res_rem = prod[PW-1:WIDTH]; res_flags.arith = 1'b1; end
        // Only reached with B == 0; nonzero divisors go to the divider
        OP_DIV:  begin res_alu = '1; res_rem = A; res_flags.div0 = 1'b1; res_flags.arith = 1'b1; end
        OP_AND:  begin res_alu = A & B;    res_flags.logic_op = 1'b1; end
        OP_OR:   begin res_alu = A | B;    res_flags.logic_op = 1'b1; end
        OP_NAND: begin res_alu = ~(A & B); res_flags.logic_op = 1'b1; end
        OP_NOR:  begin res_alu = ~(A | B); res_flags.logic_op = 1'b1; end
        OP_XOR:  begin res_alu = A ^ B;    res_flags.logic_op = 1'b1; end
        OP_XNOR: begin res_alu = ~(A ^ B); res_flags.logic_op = 1'b1; end
        OP_EQ:   begin res_alu = (A == B) ? WIDTH'(1) : '0; res_flags.cmp = 1'b1; end
        OP_GT:   begin res_alu = (A > B)  ? WIDTH'(2) : '0; res_flags.cmp = 1'b1; end
        OP_LT:   begin res_alu = (A < B)  ? WIDTH'(3) : '0; res_flags.cmp = 1'b1; end
        OP_SHR:  begin res_alu = A >> 1;   res_flags.shift = 1'b1; end
        OP_SHL:  begin res_alu = A << 1;   res_flags.shift = 1'b1; end
        default: ;
      endcase
    end
    if (res_valid) res_flags.zero = (res_alu == '0);
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      rem_q   <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= res_valid;
      alu_q   <= res_alu;
      rem_q   <= res_rem;
      flags_q <= res_flags;
    end
  end

  assign BUSY       = div_busy;
  assign OUT_VALID  = valid_q;
  assign ALU_OUT    = alu_q;
  assign REM_OUT    = rem_q;
  assign Carry_Flag = flags_q.carry;
  assign Arith_flag = flags_q.arith;
  assign Logic_flag = flags_q.logic_op;
  assign CMP_flag   = flags_q.cmp;
  assign Shift_flag = flags_q.shift;
  assign Zero_flag  = flags_q.zero;
  assign DIV0_flag  = flags_q.div0;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: a WIDTH=16 instance for the main
// sequence and a WIDTH=8 instance for the narrow-width regression.
module tb_alu_seq_param;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic [15:0] A, B;
  logic [3:0]  ALU_FUN;
  logic        BUSY, OUT_VALID;
  logic [15:0] ALU_OUT, REM_OUT;
  logic        Carry_Flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag, Zero_flag, DIV0_flag;

  logic        v8;
  logic [7:0]  a8, b8;
  logic [3:0]  f8;
  logic        busy8, ov8;
  logic [7:0]  alu8, rem8;
  logic        c8, ar8, lg8, cm8, sh8, z8, d08;

  logic [6:0]  flags16, flags8;
  int          n_checks, n_errors;
  int          cyc, busy_cnt, ov_cnt;

  // Flag order: carry, arith, logic, cmp, shift, zero, div0
  assign flags16 = {Carry_Flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag, Zero_flag, DIV0_flag};
  assign flags8  = {c8, ar8, lg8, cm8, sh8, z8, d08};

  always #5 CLK = ~CLK;

  alu_seq_param #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .BUSY(BUSY), .OUT_VALID(OUT_VALID), .ALU_OUT(ALU_OUT), .REM_OUT(REM_OUT),
    .Carry_Flag(Carry_Flag), .Arith_flag(Arith_flag), .Logic_flag(Logic_flag),
    .CMP_flag(CMP_flag), .Shift_flag(Shift_flag), .Zero_flag(Zero_flag), .DIV0_flag(DIV0_flag)
  );

  alu_seq_param #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .IN_VALID(v8), .A(a8), .B(b8), .ALU_FUN(f8),
    .BUSY(busy8), .OUT_VALID(ov8), .ALU_OUT(alu8), .REM_OUT(rem8),
    .Carry_Flag(c8), .Arith_flag(ar8), .Logic_flag(lg8),
    .CMP_flag(cm8), .Shift_flag(sh8), .Zero_flag(z8), .DIV0_flag(d08)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    RST = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = OP_ADD;
    v8 = 1'b0; a8 = '0; b8 = '0; f8 = OP_ADD;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_busy",      64'(BUSY),      64'd0);
    chk("rst_alu_out",   64'(ALU_OUT),   64'd0);
    chk("rst_rem_out",   64'(REM_OUT),   64'd0);
    chk("rst_flags",     64'(flags16),   64'd0);
    chk("rst_alu8",      64'(alu8),      64'd0);

    // Add with carry-out, request in first cycle out of reset
    RST = 1'b1; IN_VALID = 1'b1; ALU_FUN = OP_ADD; A = 16'hFFFF; B = 16'h0001;
    tick(); IN_VALID = 1'b0;
    chk("add_valid", 64'(OUT_VALID), 64'd1);
    chk("add_alu",   64'(ALU_OUT),   64'h0000);
    chk("add_rem",   64'(REM_OUT),   64'h0000);
    chk("add_flags", 64'(flags16),   64'b1100010);
    tick();
    chk("hold_valid", 64'(OUT_VALID), 64'd0);
    chk("hold_flags", 64'(flags16),   64'b1100010);

    // Subtract with borrow
    IN_VALID = 1'b1; ALU_FUN = OP_SUB; A = 16'd3; B = 16'd5;
    tick(); IN_VALID = 1'b0;
    chk("sub_alu",   64'(ALU_OUT), 64'hFFFE);
    chk("sub_flags", 64'(flags16), 64'b1100000);

    // Divide 1000/7; operands scrambled after acceptance
    IN_VALID = 1'b1; ALU_FUN = OP_DIV; A = 16'd1000; B = 16'd7;
    tick(); IN_VALID = 1'b0; A = 16'h5555; B = 16'h0003; ALU_FUN = OP_XOR;
    chk("div_busy_start", 64'(BUSY), 64'd1);
    cyc = 1; busy_cnt = 0;
    while (!OUT_VALID && cyc < 40) begin
      if (BUSY) busy_cnt++;
      tick(); cyc++;
    end
    chk("div_latency",     64'(cyc),      64'd17);
    chk("div_busy_cycles", 64'(busy_cnt), 64'd16);
    chk("div_busy_at_ov",  64'(BUSY),     64'd0);
    chk("div_quot",        64'(ALU_OUT),  64'd142);
    chk("div_rem",         64'(REM_OUT),  64'd6);
    chk("div_flags",       64'(flags16),  64'b0100000);
    tick();
    chk("div_ov_pulse", 64'(OUT_VALID), 64'd0);

    // Divide by zero
    IN_VALID = 1'b1; ALU_FUN = OP_DIV; A = 16'd5; B = 16'd0;
    tick(); IN_VALID = 1'b0;
    chk("div0_valid", 64'(OUT_VALID), 64'd1);
    chk("div0_busy",  64'(BUSY),      64'd0);
    chk("div0_alu",   64'(ALU_OUT),   64'hFFFF);
    chk("div0_rem",   64'(REM_OUT),   64'd5);
    chk("div0_flags", 64'(flags16),   64'b0100001);

    // Multiply
    IN_VALID = 1'b1; ALU_FUN = OP_MUL; A = 16'h1234; B = 16'h0100;
    tick(); IN_VALID = 1'b0;
    chk("mul_alu",   64'(ALU_OUT), 64'h3400);
    chk("mul_rem",   64'(REM_OUT), 64'h0012);
    chk("mul_flags", 64'(flags16), 64'b0100000);

    // Divide while IN_VALID pulses; pulses must be ignored
    IN_VALID = 1'b1; ALU_FUN = OP_DIV; A = 16'hFFFF; B = 16'h0010;
    tick(); ALU_FUN = OP_ADD; A = 16'd1; B = 16'd1;
    cyc = 1;
    while (!OUT_VALID && cyc < 40) begin
      IN_VALID = (cyc % 2 == 1);
      tick(); cyc++;
    end
    IN_VALID = 1'b0;
    chk("ign_latency", 64'(cyc),     64'd17);
    chk("ign_quot",    64'(ALU_OUT), 64'h0FFF);
    chk("ign_rem",     64'(REM_OUT), 64'h000F);

    // Request on the divide's OUT_VALID cycle is accepted
    IN_VALID = 1'b1; ALU_FUN = OP_XOR; A = 16'h00FF; B = 16'h0F0F;
    tick(); IN_VALID = 1'b0;
    chk("b2b_valid", 64'(OUT_VALID), 64'd1);
    chk("b2b_alu",   64'(ALU_OUT),   64'h0FF0);
    chk("b2b_rem",   64'(REM_OUT),   64'h0000);
    chk("b2b_flags", 64'(flags16),   64'b0010000);

    // Reset in DIV cycle 5 aborts the divide
    IN_VALID = 1'b1; ALU_FUN = OP_DIV; A = 16'd1000; B = 16'd7;
    tick(); IN_VALID = 1'b0;
    repeat (4) tick();
    chk("rdiv_busy", 64'(BUSY), 64'd1);
    RST = 1'b0;
    tick();
    chk("rdiv_valid", 64'(OUT_VALID), 64'd0);
    chk("rdiv_busy0", 64'(BUSY),      64'd0);
    chk("rdiv_alu",   64'(ALU_OUT),   64'd0);
    chk("rdiv_rem",   64'(REM_OUT),   64'd0);
    chk("rdiv_flags", 64'(flags16),   64'd0);
    RST = 1'b1; IN_VALID = 1'b1; ALU_FUN = OP_LT; A = 16'd3; B = 16'd9;
    tick(); IN_VALID = 1'b0;
    chk("lt_valid", 64'(OUT_VALID), 64'd1);
    chk("lt_alu",   64'(ALU_OUT),   64'd3);
    chk("lt_flags", 64'(flags16),   64'b0001000);
    ov_cnt = 0;
    repeat (20) begin
      tick();
      if (OUT_VALID) ov_cnt++;
    end
    chk("abort_no_ov", 64'(ov_cnt), 64'd0);

    // Compare false, then opcode 15 on consecutive cycles
    IN_VALID = 1'b1; ALU_FUN = OP_GT; A = 16'd3; B = 16'd9;
    tick();
    chk("gt_alu",   64'(ALU_OUT), 64'd0);
    chk("gt_flags", 64'(flags16), 64'b0001010);
    ALU_FUN = OP_ZERO; A = 16'd7; B = 16'd7;
    tick(); IN_VALID = 1'b0;
    chk("z15_valid", 64'(OUT_VALID), 64'd1);
    chk("z15_alu",   64'(ALU_OUT),   64'd0);
    chk("z15_flags", 64'(flags16),   64'b0000010);

    // WIDTH=8 regression
    v8 = 1'b1; f8 = OP_SUB; a8 = 8'h00; b8 = 8'h01;
    tick();
    chk("w8_sub_valid", 64'(ov8),    64'd1);
    chk("w8_sub_alu",   64'(alu8),   64'hFF);
    chk("w8_sub_flags", 64'(flags8), 64'b1100000);
    f8 = OP_SHL; a8 = 8'h81;
    tick(); v8 = 1'b0;
    chk("w8_shl_alu",   64'(alu8),   64'h02);
    chk("w8_shl_flags", 64'(flags8), 64'b0000100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width; legal range 4..64.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 IN_VALID  input  1  request strobe; sampled every CLK edge.
REQ-005 A  input  WIDTH  operand A, unsigned.
REQ-006 B  input  WIDTH  operand B, unsigned.
REQ-007 ALU_FUN  input  4  opcode.
REQ-008 BUSY  output  1  high while an iterative divide is in progress.
REQ-009 OUT_VALID  output  1  one-cycle pulse marking a new result.
REQ-010 ALU_OUT  output  WIDTH  primary result.
REQ-011 REM_OUT  output  WIDTH  divide remainder, or multiply high half.
REQ-012 Carry_Flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag, Zero_flag, DIV0_flag  output  1 each  result flags.

Function
REQ-013 A request SHALL be accepted on a CLK edge where IN_VALID=1 and BUSY=0; IN_VALID while BUSY=1 SHALL be ignored, with no queuing.
REQ-014 Opcode map: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 nand, 7 nor, 8 xor, 9 xnor, 10 eq->1, 11 gt->2, 12 lt->3 (0 when false), 13 A>>1, 14 A<<1, 15 ALU_OUT=0 with all class flags 0.
REQ-015 Add/sub: ALU_OUT = low WIDTH bits; Carry_Flag = bit WIDTH of the (WIDTH+1)-bit result (sub: 1 = borrow); Carry_Flag SHALL be 0 for all other opcodes.
REQ-016 Mul: full 2*WIDTH-bit product; low half -> ALU_OUT, high half -> REM_OUT.
REQ-017 Non-div opcodes, and div with B=0: latency 1; OUT_VALID and results appear the edge after acceptance; BUSY stays 0.
REQ-018 Div with B!=0: restoring divider, one quotient bit per cycle; FSM IDLE -> DIV on accept; DIV held exactly WIDTH cycles (counter WIDTH-1 down to 0); DIV -> IDLE at counter 0; OUT_VALID on edge WIDTH+1 after acceptance, quotient -> ALU_OUT, remainder -> REM_OUT.
REQ-019 BUSY SHALL be 1 exactly while FSM is in DIV; BUSY=0 in the OUT_VALID cycle, so a new request MAY be accepted back-to-back.
REQ-020 Div by zero: ALU_OUT = all ones, REM_OUT = A, DIV0_flag=1; DIV0_flag=0 for every other result.
REQ-021 Class flags one-hot per result: Arith (0-3), Logic (4-9), CMP (10-12), Shift (13-14); all 0 for opcode 15.
REQ-022 Zero_flag = (ALU_OUT==0) of the result being presented.
REQ-023 REM_OUT SHALL be 0 for opcodes other than mul and div.
REQ-024 ALU_OUT, REM_OUT and all flags are registered and SHALL hold their value until the next OUT_VALID; OUT_VALID=0 in all other cycles.
REQ-025 Operands and opcode SHALL be captured at acceptance; changes on A/B/ALU_FUN during DIV SHALL NOT affect the result.

Reset
REQ-026 When RST=0 at a CLK edge: FSM -> IDLE, counter=0, BUSY=0, OUT_VALID=0, ALU_OUT=0, REM_OUT=0, all flags=0.
REQ-027 Reset during DIV SHALL abort the divide with no OUT_VALID; a request presented in the first cycle with RST=1 SHALL be accepted.

Structure
REQ-028 A shared package alu_pkg SHALL hold the opcode localparams and the FSM state encoding (IDLE, DIV).
REQ-029 The iterative divider SHALL be one sub-module, alu_div_iter (start/done handshake, WIDTH-parametrised); all other logic resides in the top module.

Verification
REQ-030 WIDTH=16, add A=0xFFFF B=0x0001 -> next cycle OUT_VALID=1, ALU_OUT=0, Carry=1, Zero=1, Arith=1.
REQ-031 WIDTH=16, div A=1000 B=7 -> BUSY high 16 cycles, OUT_VALID on cycle 17, ALU_OUT=142, REM_OUT=6.
REQ-032 Div A=5 B=0 -> latency 1, ALU_OUT=0xFFFF, REM_OUT=5, DIV0_flag=1, BUSY never 1.
REQ-033 Mul A=0x1234 B=0x0100 -> ALU_OUT=0x3400, REM_OUT=0x0012; then IN_VALID pulses during a divide are ignored, and a request on the divide's OUT_VALID cycle is accepted.
REQ-034 RST=0 at DIV cycle 5 -> no OUT_VALID, all outputs 0; lt A=3 B=9 on the next cycle -> ALU_OUT=3, CMP=1.
REQ-035 WIDTH=8 regression: sub 0x00-0x01 -> ALU_OUT=0xFF, Carry=1; shift-left 0x81 -> 0x02, Shift=1.
